// File: rtl/seg7_pkg.sv
//------------------------------------------------------------------------------
// Module  : seg7_pkg
// Brief   : Shared 7-segment digit patterns (active-low {g,f,e,d,c,b,a}) and
//           the pair-encoder FSM state type.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

    localparam logic [6:0] c_SEG_0     = 7'h40;
    localparam logic [6:0] c_SEG_1     = 7'h79;
    localparam logic [6:0] c_SEG_2     = 7'h24;
    localparam logic [6:0] c_SEG_3     = 7'h30;
    localparam logic [6:0] c_SEG_4     = 7'h19;
    localparam logic [6:0] c_SEG_5     = 7'h12;
    localparam logic [6:0] c_SEG_6     = 7'h02;
    localparam logic [6:0] c_SEG_7     = 7'h78;
    localparam logic [6:0] c_SEG_8     = 7'h00;
    localparam logic [6:0] c_SEG_9     = 7'h10;
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } seg7_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_digit_lookup.sv
//------------------------------------------------------------------------------
// Module  : seg7_digit_lookup
// Brief   : Combinational 7-segment pattern to decimal digit decoder with a
//           legal-pattern flag; anything outside 0..9 (blank included) is illegal.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_digit_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (pattern)
            c_SEG_0: digit = 4'd0;
            c_SEG_1: digit = 4'd1;
            c_SEG_2: digit = 4'd2;
            c_SEG_3: digit = 4'd3;
            c_SEG_4: digit = 4'd4;
            c_SEG_5: digit = 4'd5;
            c_SEG_6: digit = 4'd6;
            c_SEG_7: digit = 4'd7;
            c_SEG_8: digit = 4'd8;
            c_SEG_9: digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_pair_encoder.sv
//------------------------------------------------------------------------------
// Module  : seg7_pair_encoder
// Brief   : Debounces a tens/units 7-segment pair and reports it as a 0..15
//           value, pulsing value_valid on change or pattern_err on bad pairs.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_pair_encoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_lo,
    input  logic [6:0] seg_hi,
    input  logic       sample,
    output logic [3:0] value,
    output logic       value_valid,
    output logic       pattern_err,
    output logic       busy
);

    localparam logic [3:0] c_STABLE = 4'(STABLE_CYCLES);

    seg7_state_t r_state, w_state_nxt;
    logic [3:0]  r_count, w_count_nxt;
    logic [6:0]  r_cap_hi, w_cap_hi_nxt;
    logic [6:0]  r_cap_lo, w_cap_lo_nxt;
    logic [3:0]  r_value, w_value_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err, w_err_nxt;
    logic        r_have_last, w_have_last_nxt;
    logic [3:0]  r_last_value, w_last_value_nxt;
    logic        w_enter_report;

    logic [3:0]  w_hi_digit, w_lo_digit;
    logic        w_hi_legal, w_lo_legal;
    logic        w_pair_legal;
    logic [3:0]  w_pair_value;
    logic        w_suppress;
    logic        w_match;
    logic [3:0]  w_count_inc;

    seg7_digit_lookup u_lookup_hi (
        .pattern (seg_hi),
        .digit   (w_hi_digit),
        .legal   (w_hi_legal)
    );

    seg7_digit_lookup u_lookup_lo (
        .pattern (seg_lo),
        .digit   (w_lo_digit),
        .legal   (w_lo_legal)
    );

    // The result is decoded from the live inputs: on the edge entering REPORT
    // they are either freshly captured or equal to the captured pair.
    assign w_pair_legal = w_hi_legal && w_lo_legal &&
                          ((w_hi_digit == 4'd0) ||
                           ((w_hi_digit == 4'd1) && (w_lo_digit <= 4'd5)));
    assign w_pair_value = (w_hi_digit == 4'd1) ? (4'd10 + w_lo_digit) : w_lo_digit;
    assign w_suppress   = r_have_last && (r_last_value == w_pair_value);
    assign w_match      = (seg_hi == r_cap_hi) && (seg_lo == r_cap_lo);
    assign w_count_inc  = r_count + 4'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_cap_hi_nxt     = r_cap_hi;
        w_cap_lo_nxt     = r_cap_lo;
        w_value_nxt      = r_value;
        w_valid_nxt      = 1'b0;
        w_err_nxt        = 1'b0;
        w_have_last_nxt  = r_have_last;
        w_last_value_nxt = r_last_value;
        w_enter_report   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (sample) begin
                    w_cap_hi_nxt = seg_hi;
                    w_cap_lo_nxt = seg_lo;
                    w_count_nxt  = 4'd1;
                    if (c_STABLE == 4'd1) begin
                        w_enter_report = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!sample) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 4'd0;
                end else if (w_match) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_STABLE) begin
                        w_enter_report = 1'b1;
                    end
                end else begin
                    w_cap_hi_nxt = seg_hi;
                    w_cap_lo_nxt = seg_lo;
                    w_count_nxt  = 4'd1;
                end
            end
            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = 4'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = 4'd0;
            end
        endcase

        // Error pairs always pulse; legal pairs pulse only when they differ
        // from the last reported legal value.
        if (w_enter_report) begin
            w_state_nxt = ST_REPORT;
            if (!w_pair_legal) begin
                w_err_nxt = 1'b1;
            end else if (!w_suppress) begin
                w_valid_nxt      = 1'b1;
                w_value_nxt      = w_pair_value;
                w_have_last_nxt  = 1'b1;
                w_last_value_nxt = w_pair_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_cap_hi     <= c_SEG_BLANK;
            r_cap_lo     <= c_SEG_BLANK;
            r_value      <= 4'd0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_have_last  <= 1'b0;
            r_last_value <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_cap_hi     <= w_cap_hi_nxt;
            r_cap_lo     <= w_cap_lo_nxt;
            r_value      <= w_value_nxt;
            r_valid      <= w_valid_nxt;
            r_err        <= w_err_nxt;
            r_have_last  <= w_have_last_nxt;
            r_last_value <= w_last_value_nxt;
        end
    end

    assign value       = r_value;
    assign value_valid = r_valid;
    assign pattern_err = r_err;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_seg7_pair_encoder.sv
//------------------------------------------------------------------------------
// Module  : tb_seg7_pair_encoder
// Brief   : Directed self-checking bench; two instances (STABLE_CYCLES 4 and 1)
//           checked every cycle against a behavioural model plus literal checks.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg7_pair_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample = 1'b0;
    logic [6:0] seg_hi = 7'h7F;
    logic [6:0] seg_lo = 7'h7F;

    logic [3:0] value0, value1;
    logic       valid0, valid1, err0, err1, busy0, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_pair_encoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg_lo(seg_lo), .seg_hi(seg_hi), .sample(sample),
        .value(value0), .value_valid(valid0), .pattern_err(err0), .busy(busy0)
    );

    seg7_pair_encoder #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .seg_lo(seg_lo), .seg_hi(seg_hi), .sample(sample),
        .value(value1), .value_valid(valid1), .pattern_err(err1), .busy(busy1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int digit_of(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (pats[i] == p) return i;
        return -1;
    endfunction

    int         stab [2] = '{4, 1};
    int         run [2];
    bit         rep [2];
    bit         have [2];
    int         last [2];
    int         m_value [2];
    bit         m_valid [2];
    bit         m_err [2];
    logic [6:0] held_hi [2];
    logic [6:0] held_lo [2];
    bit         m_ready = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            if (rst) begin
                run[k] = 0; rep[k] = 1'b0; have[k] = 1'b0;
                last[k] = 0; m_value[k] = 0;
            end else if (rep[k]) begin
                rep[k] = 1'b0;
                run[k] = 0;
            end else if (sample) begin
                if (run[k] > 0 && seg_hi == held_hi[k] && seg_lo == held_lo[k]) begin
                    run[k]++;
                end else begin
                    held_hi[k] = seg_hi;
                    held_lo[k] = seg_lo;
                    run[k] = 1;
                end
                if (run[k] == stab[k]) begin
                    int h, l, v;
                    rep[k] = 1'b1;
                    run[k] = 0;
                    h = digit_of(seg_hi);
                    l = digit_of(seg_lo);
                    v = h * 10 + l;
                    if (h < 0 || l < 0 || h > 1 || v > 15) begin
                        m_err[k] = 1'b1;
                    end else if (!(have[k] && last[k] == v)) begin
                        m_valid[k] = 1'b1;
                        m_value[k] = v;
                        last[k]    = v;
                        have[k]    = 1'b1;
                    end
                end
            end else begin
                run[k] = 0;
            end
        end
        if (rst) m_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model value[%0d]", k), int'(k ? value1 : value0), m_value[k]);
                chk($sformatf("model value_valid[%0d]", k), int'(k ? valid1 : valid0), int'(m_valid[k]));
                chk($sformatf("model pattern_err[%0d]", k), int'(k ? err1 : err0), int'(m_err[k]));
                chk($sformatf("model busy[%0d]", k), int'(k ? busy1 : busy0),
                    int'(rep[k] || run[k] > 0));
                chk($sformatf("exclusive pulses[%0d]", k),
                    int'(k ? (valid1 && err1) : (valid0 && err0)), 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int npv, npe, nbusy_lo;

    task automatic step(input logic [6:0] h, input logic [6:0] l,
                        input logic s, input logic r);
        @(negedge clk);
        seg_hi = h; seg_lo = l; sample = s; rst = r;
        @(posedge clk);
        #1;
        npv += int'(valid0);
        npe += int'(err0);
        if (!busy0) nbusy_lo++;
    endtask

    task automatic clr();
        npv = 0; npe = 0; nbusy_lo = 0;
    endtask

    initial begin
        clr();
        step(7'h7F, 7'h7F, 1'b0, 1'b1);
        step(7'h7F, 7'h7F, 1'b0, 1'b1);
        chk("reset value", int'(value0), 0);
        chk("reset value_valid", int'(valid0), 0);
        chk("reset pattern_err", int'(err0), 0);
        chk("reset busy", int'(busy0), 0);

        // 13: three edges settle, fourth reports
        clr();
        for (int i = 0; i < 3; i++) step(7'h79, 7'h30, 1'b1, 1'b0);
        chk("13 no early pulse", npv, 0);
        step(7'h79, 7'h30, 1'b1, 1'b0);
        chk("13 pulse after 4th edge", int'(valid0), 1);
        chk("13 value", int'(value0), 13);

        clr();
        for (int i = 0; i < 8; i++) step(7'h79, 7'h30, 1'b1, 1'b0);
        chk("13 held no repeat", npv + npe, 0);

        clr();
        for (int i = 0; i < 6; i++) step(7'h79, 7'h19, 1'b1, 1'b0);
        chk("14 single pulse", npv, 1);
        chk("14 value", int'(value0), 14);
        step(7'h79, 7'h19, 1'b0, 1'b0);

        clr();
        for (int i = 0; i < 5; i++) step(7'h79, 7'h02, 1'b1, 1'b0);
        chk("16 err pulse", npe, 1);
        chk("16 no valid", npv, 0);
        chk("16 value held", int'(value0), 14);

        clr();
        for (int i = 0; i < 5; i++) step(7'h40, 7'h7F, 1'b1, 1'b0);
        chk("blank err pulse", npe, 1);
        chk("blank value held", int'(value0), 14);
        step(7'h40, 7'h7F, 1'b0, 1'b0);

        clr();
        for (int i = 0; i < 10; i++)
            step(7'h40, (i % 2 == 0) ? 7'h40 : 7'h79, 1'b1, 1'b0);
        chk("alternate no pulse", npv + npe, 0);
        chk("alternate busy", nbusy_lo, 0);
        step(7'h40, 7'h79, 1'b0, 1'b0);
        chk("abort busy", int'(busy0), 0);
        chk("abort no pulse", npv + npe + int'(valid0), 0);

        // reset on the edge that would enter REPORT
        clr();
        for (int i = 0; i < 3; i++) step(7'h40, 7'h24, 1'b1, 1'b0);
        step(7'h40, 7'h24, 1'b1, 1'b1);
        chk("rst-report value_valid", int'(valid0), 0);
        chk("rst-report pattern_err", int'(err0), 0);
        chk("rst-report value", int'(value0), 0);
        chk("rst-report busy", int'(busy0), 0);
        chk("rst-report no pulse", npv + npe, 0);
        clr();
        for (int i = 0; i < 4; i++) step(7'h40, 7'h24, 1'b1, 1'b0);
        chk("resettle pulse", int'(valid0), 1);
        chk("resettle value", int'(value0), 2);

        clr();
        step(7'h40, 7'h24, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(7'h79, 7'h12, 1'b1, 1'b0);
        chk("15 pulse", npv, 1);
        chk("15 value", int'(value0), 15);

        // single-cycle settle instance
        step(7'h79, 7'h12, 1'b0, 1'b0);
        step(7'h40, 7'h10, 1'b1, 1'b0);
        chk("S1 pulse", int'(valid1), 1);
        chk("S1 value", int'(value1), 9);
        step(7'h40, 7'h10, 1'b0, 1'b0);
        chk("S1 pulse ends", int'(valid1), 0);
        step(7'h40, 7'h10, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_pair_encoder.md
SEG7_PAIR_ENCODER -- requirements
Module: seg7_pair_encoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal range 1..15: consecutive identical qualified samples required before a pair is reported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 seg_lo  input  7  units-digit segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
REQ-005 seg_hi  input  7  tens-digit segment pattern, same encoding as seg_lo.
REQ-006 sample  input  1  qualifier; the seg_hi/seg_lo pair is considered only on edges where sample=1.
REQ-007 value  output  4  last successfully decoded value, 0..15; registered.
REQ-008 value_valid  output  1  one-cycle pulse; value was updated this cycle.
REQ-009 pattern_err  output  1  one-cycle pulse; settled pair is not a legal encoding.
REQ-010 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 Legal digit patterns SHALL be 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10; every other pattern, including blank 0x7F, SHALL be illegal.
REQ-012 Pair mapping SHALL be: hi=0 and lo 0..9 -> value=lo; hi=1 and lo 0..5 -> value=10+lo; all other combinations, including any illegal digit, SHALL be an error.
REQ-013 FSM states SHALL be IDLE, SETTLE, REPORT.
REQ-014 IDLE: on an edge with sample=1, capture the pair and set count=1; go to REPORT if STABLE_CYCLES=1, else go to SETTLE; with sample=0, stay in IDLE.
REQ-015 SETTLE, sample=1 and inputs equal capture: count increments; reaching STABLE_CYCLES goes to REPORT.
REQ-016 SETTLE, sample=1 and inputs differ: recapture the new pair, count=1, stay in SETTLE.
REQ-017 SETTLE, sample=0: abort to IDLE with no output pulse.
REQ-018 The transition into REPORT SHALL register the result on the same edge; value_valid or pattern_err is therefore high for exactly the one cycle the FSM spends in REPORT.
REQ-019 REPORT SHALL last one cycle, ignore all inputs, and return to IDLE.
REQ-020 Change suppression: if the settled pair decodes legally and equals the last reported legal pair, no pulse SHALL be emitted; an error pair SHALL always pulse pattern_err.
REQ-021 On error, value SHALL hold its previous content, and the last-reported-pair memory SHALL be left unchanged.
REQ-022 value_valid and pattern_err SHALL never be high in the same cycle.
REQ-023 Latency: with sample held high and the pair constant, the pulse SHALL occupy the cycle after the STABLE_CYCLES-th sampling edge, counting the capture edge as 1.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, count=0, value=0, value_valid=0, pattern_err=0, busy=0, and clear the last-reported memory so the next legal pair always reports.
REQ-025 rst asserted in SETTLE or REPORT SHALL discard the pending result with no pulse; rst has priority over all other inputs.

Structure
REQ-026 Shared package seg7_pkg SHALL hold the ten digit-pattern constants, the blank constant, and the FSM state type.
REQ-027 A combinational sub-module seg7_digit_lookup (7-bit pattern -> 4-bit digit + legal flag) SHALL be instantiated twice, once for hi and once for lo.
REQ-028 Counter width SHALL be 4 bits; no other arithmetic beyond the 10+lo add.

Verification
REQ-029 STABLE_CYCLES=4, hi=0x79, lo=0x30, sample high 4 edges -> value=13, value_valid single pulse in cycle after 4th edge.
REQ-030 Same pair held for a further 8 edges -> no further pulses; then lo=0x19 settled -> value=14 pulse.
REQ-031 hi=0x79, lo=0x02 (16) settled -> pattern_err pulse, value stays 14; hi=0x40, lo=0x7F -> pattern_err.
REQ-032 lo alternates 0x40/0x79 every edge for 10 edges -> no pulse, busy high throughout; sample dropped in SETTLE -> IDLE, no pulse.
REQ-033 rst asserted on the edge that would enter REPORT -> no pulse, all outputs 0; same pair re-settled afterwards -> reports again.
REQ-034 STABLE_CYCLES=1, hi=0x40, lo=0x10 on one sample edge -> value=9 pulse on the next cycle.
